aes_key_expand: RTL and testbench

Iterative AES-128 key schedule generator. It sits directly downstream of the S-box and consumes its output for SubWord. A 128-bit cipher key is loaded on start, and round keys 0..10 are streamed out, one per accepted transfer, over a valid/ready handshake to the AddRoundKey stage of the unrolled datapath. Four S-box lookups (one 32-bit word) are used per round.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_sbox.sv | 34 +++
 rtl/aes_sub_word.sv | 16 +
 rtl/aes_key_expand.sv | 106 ++++++++++
 tb/tb_aes_key_expand.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, FSM encoding, word type, RCON table and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned ROUND_W    = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam byte_t RCON [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant for rounds 0..9; anything else yields zero.
  function automatic byte_t rcon_of(input logic [ROUND_W-1:0] rnd);
    byte_t r;
    r = 8'h00;
    for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
      if (rnd == ROUND_W'(i)) r = RCON[i];
    end
    return r;
  endfunction

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic byte_t gf_xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t s;
    p = 8'h00;
    s = a;
    for (int unsigned i = 0; i < BYTE_W; i++) begin
      if (b[i]) p = p ^ s;
      s = gf_xtime(s);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] in_i,
  output logic [BYTE_W-1:0] out_o
);

  byte_t inv_c;
  byte_t sq_c;
  byte_t aff_c;

  // x^254 == x^-1 for x != 0, and naturally maps 0 to 0.
  always_comb begin
    inv_c = 8'h01;
    sq_c  = in_i;
    for (int unsigned i = 1; i < BYTE_W; i++) begin
      sq_c  = gf_mul(sq_c, sq_c);
      inv_c = gf_mul(inv_c, sq_c);
    end
  end

  always_comb begin
    aff_c = inv_c
          ^ {inv_c[6:0], inv_c[7]}
          ^ {inv_c[5:0], inv_c[7:6]}
          ^ {inv_c[4:0], inv_c[7:5]}
          ^ {inv_c[3:0], inv_c[7:4]}
          ^ 8'h63;
  end

  assign out_o = aff_c;

endmodule

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: one S-box per byte, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    aes_sbox u_sbox (
      .in_i  (word_i[g*BYTE_W +: BYTE_W]),
      .out_o (word_o[g*BYTE_W +: BYTE_W])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: streams round keys 0..10 over a valid/ready handshake.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
  parameter int unsigned KEY_W      = aes_pkg::KEY_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KEY_W-1:0]     key_in,
  output logic                 busy,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [ROUND_W-1:0]   rk_round,
  output logic [KEY_W-1:0]     rk_out,
  output logic                 done
);

  if (NUM_ROUNDS != 10 || KEY_W != 128) begin : g_bad_param
    $error("aes_key_expand supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
  end

  state_e              state_q;
  logic [KEY_W-1:0]    rk_out_q;
  logic [ROUND_W-1:0]  rk_round_q;
  logic                rk_valid_q;
  logic                busy_q;
  logic                done_q;

  word_t               w0_c, w1_c, w2_c, w3_c;
  word_t               rot_c, sub_c, t_c;
  word_t               n0_c, n1_c, n2_c, n3_c;
  logic [KEY_W-1:0]    next_key_c;
  logic                xfer_c;
  logic                last_c;

  assign w0_c = rk_out_q[127:96];
  assign w1_c = rk_out_q[95:64];
  assign w2_c = rk_out_q[63:32];
  assign w3_c = rk_out_q[31:0];

  assign rot_c = {w3_c[23:0], w3_c[31:24]};

  aes_sub_word u_sub_word (
    .word_i (rot_c),
    .word_o (sub_c)
  );

  // Next round key derived in one cycle from the registered current key.
  assign t_c  = sub_c ^ {rcon_of(rk_round_q), 24'h000000};
  assign n0_c = w0_c ^ t_c;
  assign n1_c = w1_c ^ n0_c;
  assign n2_c = w2_c ^ n1_c;
  assign n3_c = w3_c ^ n2_c;
  assign next_key_c = {n0_c, n1_c, n2_c, n3_c};

  assign xfer_c = rk_valid_q & rk_ready;
  assign last_c = (rk_round_q == ROUND_W'(NUM_ROUNDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rk_out_q   <= key_in;
            rk_round_q <= '0;
            rk_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          // Stalled transfers leave the key, index and valid untouched.
          if (xfer_c) begin
            if (last_c) begin
              rk_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              rk_out_q   <= next_key_c;
              rk_round_q <= rk_round_q + ROUND_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_round = rk_round_q;
  assign rk_out   = rk_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a word-array FIPS-197 key expansion model.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic         done;

  int n_cmp;
  int n_bad;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZK_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZK_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: S-box table by brute-force inverse search, then word-wise expansion.
  logic [7:0]   sbox_tbl [256];
  logic [127:0] exp_rk [11];

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned acc;
    int unsigned aa;
    acc = 0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa << 1;
      if (aa >= 256) aa = aa ^ 32'h11b;
    end
    return 8'(acc);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] res;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        res[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tbl[x] = res;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_tbl[temp[31:24]], sbox_tbl[temp[23:16]], sbox_tbl[temp[15:8]], sbox_tbl[temp[7:0]]};
        temp = temp ^ {rc, 24'h0};
        rc = ref_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Observation of one expansion run.
  logic [127:0] got_key [11];
  logic [3:0]   got_rnd [11];
  int           got_cyc [11];
  int           n_xfer, stall_err, live_err, done_early;
  bit           timeout;
  logic         done_after, valid_after, busy_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] key);
    start  = 1'b1;
    key_in = key;
    tick();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic collect(input int rdy_mode, input int inject_at, input logic [127:0] inj_key);
    logic [127:0] hold_key;
    logic [3:0]   hold_rnd;
    bit           stalled, last;
    n_xfer = 0; stall_err = 0; live_err = 0; done_early = 0; timeout = 1'b1;
    done_after = 1'b0; valid_after = 1'b1; busy_after = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (done !== 1'b0) done_early++;
      if (busy !== 1'b1 || rk_valid !== 1'b1) live_err++;
      rk_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (inject_at >= 0 && rk_round == 4'(inject_at)) begin
        start  = 1'b1;
        key_in = inj_key;
      end
      stalled  = rk_valid && !rk_ready;
      hold_key = rk_out;
      hold_rnd = rk_round;
      last     = 1'b0;
      if (rk_valid && rk_ready) begin
        if (n_xfer < 11) begin
          got_key[n_xfer] = rk_out;
          got_rnd[n_xfer] = rk_round;
          got_cyc[n_xfer] = c;
        end
        n_xfer++;
        last = (rk_round == 4'd10);
      end
      tick();
      start = 1'b0;
      if (stalled && (rk_out !== hold_key || rk_round !== hold_rnd)) stall_err++;
      if (last) begin
        done_after  = done;
        valid_after = rk_valid;
        busy_after  = busy;
        timeout     = 1'b0;
        break;
      end
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    tick(); tick();
    n_cmp++;
    if ({busy, rk_valid, done, rk_round, rk_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b valid=%b done=%b round=%0d out=%h, need all zero",
               busy, rk_valid, done, rk_round, rk_out);
    end
    #3 rst = 1'b0;
    tick();
    n_cmp++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_start: got valid=%b busy=%b, need 0 0", rk_valid, busy);
    end
  endtask

  task automatic test_fips_vector();
    model_expand(KEY_A1);
    n_cmp++;
    if (exp_rk[1] !== A1_R1 || exp_rk[10] !== A1_R10) begin
      n_bad++;
      $display("FAIL model_a1: got r1=%h r10=%h, need %h %h", exp_rk[1], exp_rk[10], A1_R1, A1_R10);
    end
    do_start(KEY_A1);
    collect(0, -1, '0);
    n_cmp++;
    if (timeout || n_xfer != 11) begin
      n_bad++;
      $display("FAIL a1_count: got %0d transfers timeout=%b, need 11", n_xfer, timeout);
    end
    for (int k = 0; k < 11 && k < n_xfer; k++) begin
      n_cmp++;
      if (got_key[k] !== exp_rk[k] || got_rnd[k] !== 4'(k) || got_cyc[k] != k) begin
        n_bad++;
        $display("FAIL a1_round%0d: got key=%h rnd=%0d cyc=%0d, need key=%h rnd=%0d cyc=%0d",
                 k, got_key[k], got_rnd[k], got_cyc[k], exp_rk[k], k, k);
      end
    end
    n_cmp++;
    if (got_key[10] !== A1_R10 || got_key[1] !== A1_R1) begin
      n_bad++;
      $display("FAIL a1_known: got r1=%h r10=%h, need %h %h", got_key[1], got_key[10], A1_R1, A1_R10);
    end
    n_cmp++;
    if (done_after !== 1'b1 || busy_after !== 1'b0 || valid_after !== 1'b0 || live_err != 0 || done_early != 0) begin
      n_bad++;
      $display("FAIL a1_done: got done=%b busy=%b valid=%b live_err=%0d early=%0d, need 1 0 0 0 0",
               done_after, busy_after, valid_after, live_err, done_early);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || rk_round !== 4'd10 || rk_out !== A1_R10) begin
      n_bad++;
      $display("FAIL a1_after_done: got done=%b rnd=%0d out=%h, need 0 10 %h", done, rk_round, rk_out, A1_R10);
    end
  endtask

  task automatic test_zero_key();
    do_start('0);
    collect(0, -1, '0);
    n_cmp++;
    if (timeout || n_xfer != 11 || got_key[0] !== '0 || got_key[1] !== ZK_R1 || got_key[10] !== ZK_R10) begin
      n_bad++;
      $display("FAIL zero_key: got n=%0d r1=%h r10=%h, need 11 %h %h", n_xfer, got_key[1], got_key[10], ZK_R1, ZK_R10);
    end
    tick();
  endtask

  task automatic test_backpressure();
    model_expand(KEY_A1);
    do_start(KEY_A1);
    collect(1, -1, '0);
    n_cmp++;
    if (timeout || n_xfer != 11 || stall_err != 0) begin
      n_bad++;
      $display("FAIL bp_stall: got n=%0d stall_err=%0d timeout=%b, need 11 0 0", n_xfer, stall_err, timeout);
    end
    for (int k = 0; k < 11 && k < n_xfer; k++) begin
      n_cmp++;
      if (got_key[k] !== exp_rk[k] || got_rnd[k] !== 4'(k)) begin
        n_bad++;
        $display("FAIL bp_round%0d: got key=%h rnd=%0d, need %h %0d", k, got_key[k], got_rnd[k], exp_rk[k], k);
      end
    end
    n_cmp++;
    if (done_after !== 1'b1 || done_early != 0 || live_err != 0) begin
      n_bad++;
      $display("FAIL bp_done: got done=%b early=%0d live_err=%0d, need 1 0 0", done_after, done_early, live_err);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    do_start(KEY_A1);
    collect(1, 4, 128'h000102030405060708090a0b0c0d0e0f);
    n_cmp++;
    if (timeout || n_xfer != 11 || got_key[10] !== A1_R10 || got_key[4] !== exp_rk[4] || got_key[5] !== exp_rk[5]) begin
      n_bad++;
      $display("FAIL busy_start: got n=%0d r5=%h r10=%h, need 11 %h %h", n_xfer, got_key[5], got_key[10], exp_rk[5], A1_R10);
    end
    tick();
  endtask

  task automatic test_async_reset();
    bit reached;
    do_start(KEY_A1);
    rk_ready = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (rk_round == 4'd6) begin reached = 1'b1; break; end
      tick();
    end
    n_cmp++;
    if (!reached) begin
      n_bad++;
      $display("FAIL rst_reach6: got round=%0d, need 6", rk_round);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, rk_valid, done, rk_round, rk_out} !== '0) begin
      n_bad++;
      $display("FAIL rst_midrun: got busy=%b valid=%b done=%b round=%0d out=%h, need all zero",
               busy, rk_valid, done, rk_round, rk_out);
    end
    rk_ready = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    n_cmp++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_resume: got valid=%b busy=%b, need 0 0", rk_valid, busy);
    end
    do_start(KEY_A1);
    collect(0, -1, '0);
    for (int k = 0; k < 11; k++) begin
      n_cmp++;
      if (timeout || got_key[k] !== exp_rk[k] || got_rnd[k] !== 4'(k)) begin
        n_bad++;
        $display("FAIL rst_rerun%0d: got key=%h rnd=%0d, need %h %0d", k, got_key[k], got_rnd[k], exp_rk[k], k);
      end
    end
  endtask

  task automatic test_back_to_back();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_done: got done=%b, need 1", done);
    end
    tick();
    n_cmp++;
    if (rk_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_gap: got valid=%b done=%b, need 0 0", rk_valid, done);
    end
    do_start('0);
    n_cmp++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk_out !== '0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_round0: got valid=%b rnd=%0d out=%h busy=%b, need 1 0 0 1", rk_valid, rk_round, rk_out, busy);
    end
    collect(0, -1, '0);
    n_cmp++;
    if (timeout || n_xfer != 11 || got_key[10] !== ZK_R10) begin
      n_bad++;
      $display("FAIL b2b_r10: got n=%0d r10=%h, need 11 %h", n_xfer, got_key[10], ZK_R10);
    end
    tick();
  endtask

  task automatic test_random_keys();
    logic [127:0] key;
    for (int t = 0; t < 4; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key);
      do_start(key);
      collect(1, -1, '0);
      for (int k = 0; k < 11; k++) begin
        n_cmp++;
        if (timeout || got_key[k] !== exp_rk[k] || got_rnd[k] !== 4'(k) || stall_err != 0) begin
          n_bad++;
          $display("FAIL rand%0d_round%0d: got key=%h rnd=%0d stall_err=%0d, need %h %0d 0",
                   t, k, got_key[k], got_rnd[k], stall_err, exp_rk[k], k);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    build_sbox();
    test_reset();
    test_fips_vector();
    test_zero_key();
    test_backpressure();
    test_start_while_busy();
    test_async_reset();
    test_back_to_back();
    test_random_keys();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
